// File: rtl/gpr_pkg.sv
// Shared types and sizes for the GPR write-port controller.
package gpr_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = $clog2(NREG);

   typedef logic [REG_AW-1:0] reg_addr_t;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0] is the ALU path, req[1] the load unit.
module rr_arb2
   import gpr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   wb_src_e last_grant;

   // On a tie the side that did not win last time is granted.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_grant == WB_ALU) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Reset to MEM so the ALU wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= WB_MEM;
      end else if (advance) begin
         last_grant <= gnt[1] ? WB_MEM : WB_ALU;
      end
   end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback and
// tracks pending writes so issue stalls on RAW/WAW hazards.
module gpr_wb_arbiter
   import gpr_pkg::*;
#(
   parameter int XLEN = gpr_pkg::XLEN,
   parameter int NREG = gpr_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_rs1,
   input  logic [REG_AW-1:0] issue_rs2,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              issue_wr,
   output logic              issue_stall,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   output logic              mem_ready,
   input  logic              flush,
   output logic              gpr_we,
   output logic [REG_AW-1:0] gpr_addr_c,
   output logic [XLEN-1:0]   gpr_data_c,
   output logic              idle,
   output logic              err_unexpected_wb
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] busy_nxt;
   logic [1:0]      gnt;
   logic            xfer;
   logic            issue_acc;
   reg_addr_t       wb_rd;
   logic [XLEN-1:0] wb_data;

   // Issue side: depends only on the scoreboard and issue inputs.
   assign issue_stall = issue_valid &
                        (busy[issue_rs1] | busy[issue_rs2] | (issue_wr & busy[issue_rd]));
   assign issue_acc   = issue_valid & ~issue_stall & issue_wr & (issue_rd != '0);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({mem_valid, alu_valid}),
      .advance (xfer),
      .gnt     (gnt)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];
   assign xfer      = (alu_valid & gnt[0]) | (mem_valid & gnt[1]);
   assign wb_rd     = gnt[1] ? mem_rd   : alu_rd;
   assign wb_data   = gnt[1] ? mem_data : alu_data;

   // Set is applied after clear so an issue always wins over a commit or flush.
   always_comb begin
      set_vec             = '0;
      clr_vec             = '0;
      set_vec[issue_rd]   = issue_acc;
      clr_vec[gpr_addr_c] = gpr_we;
      busy_nxt            = flush ? set_vec : ((busy & ~clr_vec) | set_vec);
      busy_nxt[0]         = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Write stage: one registered slot feeding the register-file port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpr_we     <= 1'b0;
         gpr_addr_c <= '0;
         gpr_data_c <= '0;
      end else if (xfer) begin
         gpr_we     <= (wb_rd != '0);
         gpr_addr_c <= wb_rd;
         gpr_data_c <= wb_data;
      end else begin
         gpr_we     <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_unexpected_wb <= 1'b0;
      end else if (xfer && (wb_rd != '0) && !busy[wb_rd]) begin
         err_unexpected_wb <= 1'b1;
      end
   end

   assign idle = (busy == '0) & ~gpr_we;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a transaction-level reference model.
module tb_gpr_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_wr, issue_stall;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [4:0]  alu_rd, mem_rd;
   logic [31:0] alu_data, mem_data;
   logic        flush, gpr_we, idle, err_unexpected_wb;
   logic [4:0]  gpr_addr_c;
   logic [31:0] gpr_data_c;

   int errors = 0;
   int checks = 0;

   gpr_wb_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .issue_valid       (issue_valid),
      .issue_rs1         (issue_rs1),
      .issue_rs2         (issue_rs2),
      .issue_rd          (issue_rd),
      .issue_wr          (issue_wr),
      .issue_stall       (issue_stall),
      .alu_valid         (alu_valid),
      .alu_rd            (alu_rd),
      .alu_data          (alu_data),
      .alu_ready         (alu_ready),
      .mem_valid         (mem_valid),
      .mem_rd            (mem_rd),
      .mem_data          (mem_data),
      .mem_ready         (mem_ready),
      .flush             (flush),
      .gpr_we            (gpr_we),
      .gpr_addr_c        (gpr_addr_c),
      .gpr_data_c        (gpr_data_c),
      .idle              (idle),
      .err_unexpected_wb (err_unexpected_wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: set of pending registers, the tie-break preference,
   // and the single write slot.
   bit [31:0] m_busy, n_busy;
   bit        m_mem_first, n_mem_first;
   bit        m_we, n_we;
   bit [4:0]  m_addr, n_addr;
   bit [31:0] m_data, n_data;
   bit        m_err, n_err;

   always @(negedge clk) begin
      bit e_stall, g_alu, g_mem, acc;
      bit [4:0]  wrd;
      bit [31:0] wdat;
      e_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                                (issue_wr && m_busy[issue_rd]));
      g_alu = alu_valid && (!mem_valid || !m_mem_first);
      g_mem = mem_valid && !g_alu;

      chk("issue_stall", issue_stall, e_stall);
      if (alu_valid) chk("alu_ready", alu_ready, g_alu);
      if (mem_valid) chk("mem_ready", mem_ready, g_mem);
      chk("ready_exclusive", alu_ready && mem_ready, 0);
      chk("gpr_we", gpr_we, m_we);
      chk("gpr_addr_c", gpr_addr_c, m_addr);
      chk("gpr_data_c", gpr_data_c, m_data);
      chk("idle", idle, (m_busy == 0) && !m_we);
      chk("err_unexpected_wb", err_unexpected_wb, m_err);

      n_busy = m_busy;
      if (m_we) n_busy[m_addr] = 1'b0;
      if (flush) n_busy = '0;
      acc = issue_valid && !e_stall && issue_wr && (issue_rd != 0);
      if (acc) n_busy[issue_rd] = 1'b1;
      n_busy[0] = 1'b0;

      n_mem_first = m_mem_first;
      n_addr = m_addr;
      n_data = m_data;
      n_err  = m_err;
      n_we   = 1'b0;
      if (g_alu || g_mem) begin
         wrd  = g_alu ? alu_rd : mem_rd;
         wdat = g_alu ? alu_data : mem_data;
         n_we = (wrd != 0);
         n_addr = wrd;
         n_data = wdat;
         if (wrd != 0 && !m_busy[wrd]) n_err = 1'b1;
         n_mem_first = g_alu;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = '0; m_mem_first = 1'b0; m_we = 1'b0;
         m_addr = '0; m_data = '0; m_err = 1'b0;
      end else begin
         m_busy = n_busy; m_mem_first = n_mem_first; m_we = n_we;
         m_addr = n_addr; m_data = n_data; m_err = n_err;
      end
   end

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd;
      issue_rs1 = '0; issue_rs2 = '0;
   endtask

   task automatic probe(input string name, input logic [4:0] rs1, input logic exp);
      issue_valid = 1'b1; issue_wr = 1'b0; issue_rd = '0;
      issue_rs1 = rs1; issue_rs2 = '0;
      #1 chk(name, issue_stall, exp);
   endtask

   int        gseq[4];
   logic [4:0] got_addr[4];
   int        ng, na, ai, mi;
   logic      ga, gm;

   initial begin
      rst_n = 1'b1;
      issue_valid = 0; issue_wr = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      flush = 0;
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst_idle", idle, 1);
      chk("rst_we", gpr_we, 0);
      chk("rst_addr", gpr_addr_c, 0);
      chk("rst_data", gpr_data_c, 0);
      chk("rst_err", err_unexpected_wb, 0);
      rst_n = 1'b1;
      tick();

      // RAW hazard resolved by an ALU writeback
      issue(5'd5);
      #1 chk("issue_rd5_nostall", issue_stall, 0);
      tick();
      probe("raw_stall_rs1_5", 5'd5, 1);
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      #1;
      chk("wb5_we", gpr_we, 1);
      chk("wb5_addr", gpr_addr_c, 5);
      chk("wb5_data", gpr_data_c, 32'hDEADBEEF);
      chk("stall_until_commit", issue_stall, 1);
      tick();
      chk("stall_released", issue_stall, 0);
      issue_valid = 0;

      // rd=0 writeback is consumed silently
      mem_valid = 1; mem_rd = 5'd0; mem_data = 32'h1234;
      #1 chk("rd0_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 0;
      #1;
      chk("rd0_we", gpr_we, 0);
      chk("rd0_err", err_unexpected_wb, 0);
      tick();

      // Contention: ALU and MEM alternate
      for (int r = 10; r < 14; r++) begin
         issue(5'(r));
         tick();
      end
      issue_valid = 0;
      alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA000_000A;
      mem_valid = 1; mem_rd = 5'd11; mem_data = 32'hB000_000B;
      ai = 0; mi = 0; ng = 0; na = 0;
      for (int c = 0; c < 12 && na < 4; c++) begin
         @(negedge clk);
         ga = alu_valid && alu_ready;
         gm = mem_valid && mem_ready;
         if (ga && ng < 4) begin gseq[ng] = 0; ng++; end
         if (gm && ng < 4) begin gseq[ng] = 1; ng++; end
         tick();
         if (gpr_we && na < 4) begin got_addr[na] = gpr_addr_c; na++; end
         if (ga) begin
            ai++;
            if (ai < 2) begin alu_rd = 5'd12; alu_data = 32'hA000_000C; end
            else alu_valid = 0;
         end
         if (gm) begin
            mi++;
            if (mi < 2) begin mem_rd = 5'd13; mem_data = 32'hB000_000D; end
            else mem_valid = 0;
         end
      end
      alu_valid = 0; mem_valid = 0;
      chk("contention_writes_seen", na, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < ng) chk($sformatf("grant_order%0d", k), gseq[k], k % 2);
         if (k < na) chk($sformatf("addr_seq%0d", k), got_addr[k], 10 + k);
      end
      tick(); tick();
      chk("idle_after_drain", idle, 1);

      // Writeback to a register nothing is waiting on
      alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
      tick();
      alu_valid = 0;
      #1;
      chk("unexp_we", gpr_we, 1);
      chk("unexp_addr", gpr_addr_c, 7);
      chk("unexp_err", err_unexpected_wb, 1);
      repeat (3) tick();
      chk("err_sticky", err_unexpected_wb, 1);

      // Flush with a simultaneous accepted issue
      issue(5'd3); tick();
      issue(5'd9); tick();
      issue(5'd12); flush = 1; tick();
      flush = 0;
      probe("flush_clr3", 5'd3, 0);
      probe("flush_clr9", 5'd9, 0);
      probe("flush_keep12", 5'd12, 1);
      issue_valid = 0;
      chk("flush_not_idle", idle, 0);
      tick();

      // Asynchronous reset with a write in flight
      issue(5'd20); tick();
      issue_valid = 0;
      alu_valid = 1; alu_rd = 5'd20; alu_data = 32'h2020_2020;
      tick();
      alu_valid = 0;
      #1 chk("pre_rst_we", gpr_we, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_we", gpr_we, 0);
      chk("async_rst_idle", idle, 1);
      chk("async_rst_err", err_unexpected_wb, 0);
      tick(); tick();
      rst_n = 1'b1;
      alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1;
      mem_valid = 1; mem_rd = 5'd0; mem_data = 32'h2;
      #1;
      chk("post_rst_tie_alu", alu_ready, 1);
      chk("post_rst_tie_mem", mem_ready, 0);
      tick();
      alu_valid = 0;
      #1 chk("post_rst_mem_next", mem_ready, 1);
      tick();
      mem_valid = 0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-port controller for the general-purpose register file. It shares the file's single write port between two writeback requesters: the ALU result path and the load unit. It also keeps a per-register pending-write scoreboard, so the issue stage stalls on read-after-write and write-after-write hazards. It sits between the execute/memory stages and the register file's write port.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREG`, 32, number of registers; address width is log2(`NREG`) = 5

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `issue_valid`  in  1  issue stage presents an instruction
- `issue_rs1`, `issue_rs2`, `issue_rd`  in  5 each  source and destination registers of the issuing instruction
- `issue_wr`  in  1  instruction writes `issue_rd`
- `issue_stall`  out  1  hazard; the instruction must not issue this cycle
- `alu_valid`, `mem_valid`  in  1 each  writeback request
- `alu_rd`, `mem_rd`  in  5 each  writeback destination
- `alu_data`, `mem_data`  in  `XLEN` each  writeback value
- `alu_ready`, `mem_ready`  out  1 each  grant; a transfer occurs when valid and ready are both 1
- `flush`  in  1  synchronous scoreboard clear
- `gpr_we`  out  1  register-file write enable
- `gpr_addr_c`  out  5  register-file write address
- `gpr_data_c`  out  `XLEN`  register-file write data
- `idle`  out  1  no pending writes and no write in flight
- `err_unexpected_wb`  out  1  sticky protocol-error flag

## Operation
- Scoreboard: a `busy[NREG-1:0]` vector; `busy[0]` is hardwired to 0.
- `issue_stall` is combinational. It is high when `issue_valid` is high and any of the following holds:
  - `busy[issue_rs1]`
  - `busy[issue_rs2]`
  - `issue_wr` is high and `busy[issue_rd]`
- Issue is accepted when `issue_valid` is high, `issue_stall` is low, `issue_wr` is high and `issue_rd` != 0. On acceptance, set `busy[issue_rd]` at the clock edge.
- Arbitration: two-way round-robin on a `last_grant` bit (0 = ALU, 1 = MEM).
  - A single valid requester is granted.
  - If both are valid, the requester not in `last_grant` is granted; `last_grant` updates on each transfer.
  - `alu_ready` and `mem_ready` are combinational and never both high.
  - A ready signal may be high while its valid is low.
- Write stage: on a transfer, register the granted request's rd and data into `gpr_addr_c` and `gpr_data_c`.
  - `gpr_we` is set to 1 when rd != 0.
  - A transfer with rd = 0 is consumed with `gpr_we` = 0.
- Commit: on an edge where `gpr_we` is 1, clear `busy[gpr_addr_c]`.
- Transfer to a non-busy rd != 0: the write still proceeds and `err_unexpected_wb` sets. It clears only on reset.
- Issue set and commit clear cannot target the same register in one cycle, because the WAW stall prevents it. If both still occur, set wins.
- `flush`: on the next edge, clear all `busy` bits except a bit being set by a simultaneous issue. An in-flight write stage still commits; its clear of an already-clear bit is not an error.
- `idle` = (`busy` == 0) and `gpr_we` == 0.
- Reset values:
  - `busy` = 0
  - `last_grant` = 1, so ALU wins the first tie
  - `gpr_we` = 0, `gpr_addr_c` = 0, `gpr_data_c` = 0
  - `err_unexpected_wb` = 0
  - Because of these, `idle` = 1 during reset.
- Reset mid-operation: all state clears immediately. In-flight writes are dropped.

## Timing
- Transfer at edge N → `gpr_we` high during cycle N+1 → register file writes at edge N+1 → busy bit clears at edge N+1 → `issue_stall` falls in cycle N+2.
- Throughput: one writeback per cycle, back to back. Under contention, ALU and MEM alternate every cycle.
- Requesters hold valid, rd and data stable until the transfer.
- `issue_stall` is combinational from `busy` and the issue inputs only, with no path from the writeback inputs.

## Structure
- Shared package `gpr_pkg`:
  - `XLEN`, `NREG`, `REG_AW` = 5
  - `typedef` for the register address
  - enum `wb_src_e` {`WB_ALU`, `WB_MEM`}, used for `last_grant`
- Sub-module `rr_arb2`: two-requester round-robin arbiter. Ports: `clk`, `rst_n`, `req[1:0]`, `advance`, `gnt[1:0]`.
- Scoreboard and write stage live in the top level.

## Test plan
- Reset release, then issue rd=5 (`issue_wr`=1) → `busy[5]`=1; issue rs1=5 → `issue_stall`=1. ALU writeback rd=5, data 0xDEADBEEF → `gpr_we`=1, addr 5, data 0xDEADBEEF one cycle later; `issue_stall`=0 the following cycle.
- Both requesters valid for 4 cycles with distinct rds → grants ALU, MEM, ALU, MEM; `gpr_addr_c` sequence matches; no cycle with both readies high.
- Writeback rd=0 with data 0x1234 → handshake completes, `gpr_we` stays 0, `err_unexpected_wb` stays 0.
- Writeback to rd=7 while `busy[7]`=0 → write occurs, `err_unexpected_wb`=1 and stays 1 until `rst_n` is asserted.
- Set `busy[3]` and `busy[9]`, then assert `flush` together with an accepted issue of rd=12 → afterwards only `busy[12]`=1.
- Assert `rst_n` low asynchronously mid-cycle with `gpr_we`=1 and `busy` nonzero → `gpr_we`=0 and `busy`=0 immediately, `idle`=1; first tie after release is granted to ALU.
